// File: rtl/imu_accel_sequencer_pkg.sv
// Shared types and constants for the IMU accelerometer read sequencer.
// Init states exist only when IMU_SEQ_INIT_WRITE_EN is defined.
package imu_accel_sequencer_pkg;

   // Encodings are fixed because they are shown on the status LEDs.
`ifdef IMU_SEQ_INIT_WRITE_EN
   typedef enum logic [3:0] {
      StIdle     = 4'd0,
      StReq      = 4'd1,
      StWait     = 4'd2,
      StPublish  = 4'd3,
      StInitReq  = 4'd4,
      StInitWait = 4'd5
   } seq_state_e;
`else
   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StReq     = 4'd1,
      StWait    = 4'd2,
      StPublish = 4'd3
   } seq_state_e;
`endif

   localparam logic [6:0] IMU_ADDR_DEFAULT = 7'h68;

   localparam logic [6:0] ACCX_LSB = 7'h12;
   localparam logic [6:0] ACCX_MSB = 7'h13;
   localparam logic [6:0] ACCY_LSB = 7'h14;
   localparam logic [6:0] ACCY_MSB = 7'h15;
   localparam logic [6:0] ACCZ_LSB = 7'h16;
   localparam logic [6:0] ACCZ_MSB = 7'h17;
   localparam logic [6:0] CMD_REG  = 7'h7E;

   // Accelerometer normal-mode command.
   localparam logic [7:0] INIT_CMD = 8'h11;

   localparam int unsigned NUM_BYTES = 6;
   localparam logic [2:0]  LAST_IDX  = 3'd5;

   function automatic logic [15:0] pack_word(input logic [7:0] msb, input logic [7:0] lsb);
      return {msb, lsb};
   endfunction

endpackage

// File: rtl/imu_accel_sequencer_if.sv
// Request/response handshake between the sequencer (master side) and the I2C master block.
interface imu_accel_sequencer_if;
   logic       i2c_start;
   logic       i2c_read_write;
   logic [6:0] i2c_slave_addr;
   logic [6:0] i2c_reg_addr;
   logic [7:0] i2c_data_in;
   logic [7:0] i2c_data_out;
   logic       i2c_busy;
   logic       i2c_done;

   modport master (
      output i2c_start,
      output i2c_read_write,
      output i2c_slave_addr,
      output i2c_reg_addr,
      output i2c_data_in,
      input  i2c_data_out,
      input  i2c_busy,
      input  i2c_done
   );

   modport slave (
      input  i2c_start,
      input  i2c_read_write,
      input  i2c_slave_addr,
      input  i2c_reg_addr,
      input  i2c_data_in,
      output i2c_data_out,
      output i2c_busy,
      output i2c_done
   );
endinterface

// File: rtl/imu_seq_timeout.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module imu_seq_timeout #(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [Width-1:0] load_val_i,
   output logic             expired_o
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == '0);

endmodule

// File: rtl/imu_accel_sequencer.sv
// Reads ACCX..ACCZ (LSB, MSB) through the I2C master and publishes one atomic sample.
// Define IMU_SEQ_INIT_WRITE_EN to issue one command-register write after reset.
module imu_accel_sequencer
   import imu_accel_sequencer_pkg::*;
#(
   parameter logic [6:0]  IMU_ADDR       = IMU_ADDR_DEFAULT,
   parameter logic [6:0]  ACC_BASE_ADDR  = ACCX_LSB,
`ifdef IMU_SEQ_INIT_WRITE_EN
   parameter logic [6:0]  INIT_REG_ADDR  = CMD_REG,
   parameter logic [7:0]  INIT_DATA      = INIT_CMD,
`endif
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          trig,
   imu_accel_sequencer_if.master         i2c,
   output logic [15:0]                   acc_x,
   output logic [15:0]                   acc_y,
   output logic [15:0]                   acc_z,
   output logic                          sample_valid,
   output logic                          seq_busy,
   output logic                          err_timeout,
   output logic [3:0]                    state_ind
);

   // WAIT lasts exactly TIMEOUT_CYCLES cycles before expiry is acted on.
   localparam logic [15:0] TmoLoad = (TIMEOUT_CYCLES == 16'd0) ? 16'd0 : TIMEOUT_CYCLES - 16'd1;

   seq_state_e  state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic        pending_q, pending_d;
   logic        err_q, err_d;
   logic        start_q, start_d;
   logic [6:0]  reg_addr_q, reg_addr_d;
   logic [15:0] acc_x_q, acc_x_d;
   logic [15:0] acc_y_q, acc_y_d;
   logic [15:0] acc_z_q, acc_z_d;
   logic        valid_q, valid_d;
   logic [7:0]  byte_q [NUM_BYTES];
   logic        cap_en;
   logic        tmo_load, tmo_en, tmo_expired;

`ifdef IMU_SEQ_INIT_WRITE_EN
   logic        rw_q, rw_d;
   logic [7:0]  data_in_q, data_in_d;
   logic        init_pend_q, init_pend_d;
`endif

   imu_seq_timeout #(
      .Width (16)
   ) u_timeout (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmo_load),
      .en_i       (tmo_en),
      .load_val_i (TmoLoad),
      .expired_o  (tmo_expired)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      pending_d  = pending_q;
      err_d      = err_q;
      start_d    = 1'b0;
      reg_addr_d = reg_addr_q;
      acc_x_d    = acc_x_q;
      acc_y_d    = acc_y_q;
      acc_z_d    = acc_z_q;
      valid_d    = 1'b0;
      cap_en     = 1'b0;
      tmo_load   = 1'b0;
      tmo_en     = 1'b0;
`ifdef IMU_SEQ_INIT_WRITE_EN
      rw_d        = rw_q;
      data_in_d   = data_in_q;
      init_pend_d = init_pend_q;
`endif

      if (trig && (state_q != StIdle)) begin
         pending_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
`ifdef IMU_SEQ_INIT_WRITE_EN
            if (init_pend_q) begin
               init_pend_d = 1'b0;
               pending_d   = pending_q | trig;
               state_d     = StInitReq;
            end else
`endif
            if (trig || pending_q) begin
               pending_d = 1'b0;
               idx_d     = 3'd0;
               err_d     = 1'b0;
               state_d   = StReq;
            end
         end

         StReq: begin
            reg_addr_d = ACC_BASE_ADDR + {4'b0000, idx_q};
`ifdef IMU_SEQ_INIT_WRITE_EN
            rw_d      = 1'b1;
            data_in_d = 8'h00;
`endif
            if (!i2c.i2c_busy) begin
               start_d  = 1'b1;
               tmo_load = 1'b1;
               state_d  = StWait;
            end
         end

         StWait: begin
            tmo_en = 1'b1;
            if (i2c.i2c_done) begin
               cap_en = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = StPublish;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = StReq;
               end
            end else if (tmo_expired) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end

         StPublish: begin
            acc_x_d = pack_word(byte_q[1], byte_q[0]);
            acc_y_d = pack_word(byte_q[3], byte_q[2]);
            acc_z_d = pack_word(byte_q[5], byte_q[4]);
            valid_d = 1'b1;
            // A trig seen during the burst or in this very cycle restarts immediately.
            if (pending_q || trig) begin
               pending_d = 1'b0;
               idx_d     = 3'd0;
               err_d     = 1'b0;
               state_d   = StReq;
            end else begin
               state_d = StIdle;
            end
         end

`ifdef IMU_SEQ_INIT_WRITE_EN
         StInitReq: begin
            reg_addr_d = INIT_REG_ADDR;
            rw_d       = 1'b0;
            data_in_d  = INIT_DATA;
            if (!i2c.i2c_busy) begin
               start_d  = 1'b1;
               tmo_load = 1'b1;
               state_d  = StInitWait;
            end
         end

         StInitWait: begin
            tmo_en = 1'b1;
            if (i2c.i2c_done) begin
               state_d = StIdle;
            end else if (tmo_expired) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
`endif

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= 3'd0;
         pending_q  <= 1'b0;
         err_q      <= 1'b0;
         start_q    <= 1'b0;
         reg_addr_q <= ACC_BASE_ADDR;
         acc_x_q    <= 16'h0000;
         acc_y_q    <= 16'h0000;
         acc_z_q    <= 16'h0000;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pending_q  <= pending_d;
         err_q      <= err_d;
         start_q    <= start_d;
         reg_addr_q <= reg_addr_d;
         acc_x_q    <= acc_x_d;
         acc_y_q    <= acc_y_d;
         acc_z_q    <= acc_z_d;
         valid_q    <= valid_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            byte_q[i] <= 8'h00;
         end
      end else if (cap_en) begin
         byte_q[idx_q] <= i2c.i2c_data_out;
      end
   end

`ifdef IMU_SEQ_INIT_WRITE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rw_q        <= 1'b1;
         data_in_q   <= 8'h00;
         init_pend_q <= 1'b1;
      end else begin
         rw_q        <= rw_d;
         data_in_q   <= data_in_d;
         init_pend_q <= init_pend_d;
      end
   end

   assign i2c.i2c_read_write = rw_q;
   assign i2c.i2c_data_in    = data_in_q;
`else
   assign i2c.i2c_read_write = 1'b1;
   assign i2c.i2c_data_in    = 8'h00;
`endif

   assign i2c.i2c_start      = start_q;
   assign i2c.i2c_slave_addr = IMU_ADDR;
   assign i2c.i2c_reg_addr   = reg_addr_q;

   assign acc_x        = acc_x_q;
   assign acc_y        = acc_y_q;
   assign acc_z        = acc_z_q;
   assign sample_valid = valid_q;
   assign seq_busy     = (state_q != StIdle);
   assign err_timeout  = err_q;
   assign state_ind    = state_q;

endmodule

// File: tb/tb_imu_accel_sequencer.sv
// Directed bench for imu_accel_sequencer with a behavioural I2C master model (done D cycles after start).
module tb_imu_accel_sequencer;

   localparam int D   = 20;
   localparam int TMO = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        trig;
   logic [15:0] acc_x, acc_y, acc_z;
   logic        sample_valid, seq_busy, err_timeout;
   logic [3:0]  state_ind;

   int checks = 0;
   int errors = 0;

   imu_accel_sequencer_if bus ();

   imu_accel_sequencer #(
      .TIMEOUT_CYCLES (16'd100)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .trig         (trig),
      .i2c          (bus),
      .acc_x        (acc_x),
      .acc_y        (acc_y),
      .acc_z        (acc_z),
      .sample_valid (sample_valid),
      .seq_busy     (seq_busy),
      .err_timeout  (err_timeout),
      .state_ind    (state_ind)
   );

   always #5 clk = ~clk;

   // Master model state; mem/busy_force/drop_* are written only by the stimulus block.
   logic [7:0] mem [0:127];
   logic       busy_force = 1'b0;
   logic       drop_en    = 1'b0;
   logic [6:0] drop_reg   = 7'h00;
   int         model_cnt  = 0;
   logic [6:0] pend_addr  = 7'h00;
   int         starts_total = 0;
   int         sv_total     = 0;
   logic [6:0] log_addr [0:255];
   logic       log_rw   [0:255];
   logic [7:0] log_data [0:255];

   assign bus.i2c_busy = busy_force;

   always @(negedge clk) begin
      bus.i2c_done = 1'b0;
      if (model_cnt > 0) begin
         model_cnt--;
         if (model_cnt == 0) begin
            bus.i2c_done     = 1'b1;
            bus.i2c_data_out = mem[pend_addr];
         end
      end
      if (bus.i2c_start) begin
         if (starts_total < 256) begin
            log_addr[starts_total] = bus.i2c_reg_addr;
            log_rw[starts_total]   = bus.i2c_read_write;
            log_data[starts_total] = bus.i2c_data_in;
         end
         starts_total++;
         if (!(drop_en && (bus.i2c_reg_addr == drop_reg))) begin
            model_cnt = D;
            pend_addr = bus.i2c_reg_addr;
         end
      end
      if (sample_valid) sv_total++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Returns 1 time unit after the edge that samples trig.
   task automatic pulse_trig;
      @(negedge clk);
      trig = 1'b1;
      @(posedge clk);
      #1;
      trig = 1'b0;
   endtask

   task automatic wait_valid(input int bound, output int k, output bit ok);
      k  = 0;
      ok = 1'b0;
      while (k < bound && !ok) begin
         tick();
         k++;
         if (sample_valid) ok = 1'b1;
      end
   endtask

   task automatic wait_err(input int bound, output int k, output bit ok);
      k  = 0;
      ok = 1'b0;
      while (k < bound && !ok) begin
         tick();
         k++;
         if (err_timeout) ok = 1'b1;
      end
   endtask

   task automatic load_table(input logic [47:0] bytes);
      for (int i = 0; i < 6; i++) mem[7'h12 + 7'(i)] = bytes[8*i +: 8];
   endtask

   task automatic test_reset;
      rst  = 1'b1;
      trig = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (acc_x !== 16'h0) begin errors++; $display("FAIL reset_acc_x got %h exp 0000", acc_x); end
      checks++; if (acc_y !== 16'h0) begin errors++; $display("FAIL reset_acc_y got %h exp 0000", acc_y); end
      checks++; if (acc_z !== 16'h0) begin errors++; $display("FAIL reset_acc_z got %h exp 0000", acc_z); end
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
      checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", seq_busy); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_timeout); end
      checks++; if (bus.i2c_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", bus.i2c_start); end
      checks++; if (bus.i2c_read_write !== 1'b1) begin errors++; $display("FAIL reset_rw got %b exp 1", bus.i2c_read_write); end
      checks++; if (bus.i2c_slave_addr !== 7'h68) begin errors++; $display("FAIL reset_slave got %h exp 68", bus.i2c_slave_addr); end
      checks++; if (bus.i2c_reg_addr !== 7'h12) begin errors++; $display("FAIL reset_reg got %h exp 12", bus.i2c_reg_addr); end
      checks++; if (bus.i2c_data_in !== 8'h00) begin errors++; $display("FAIL reset_data_in got %h exp 00", bus.i2c_data_in); end
      checks++; if (state_ind !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_ind); end
      @(negedge clk);
      rst = 1'b0;
   endtask

`ifdef IMU_SEQ_INIT_WRITE_EN
   task automatic test_init;
      int k; bit ok; int s0;
      s0 = starts_total;
      pulse_trig();
      wait_valid(600, k, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL init_valid got none exp pulse"); end
      checks++; if (log_rw[s0] !== 1'b0) begin errors++; $display("FAIL init_rw got %b exp 0", log_rw[s0]); end
      checks++; if (log_addr[s0] !== 7'h7E) begin errors++; $display("FAIL init_reg got %h exp 7e", log_addr[s0]); end
      checks++; if (log_data[s0] !== 8'h11) begin errors++; $display("FAIL init_data got %h exp 11", log_data[s0]); end
      checks++; if (log_addr[s0+1] !== 7'h12) begin errors++; $display("FAIL init_first_read got %h exp 12", log_addr[s0+1]); end
      checks++; if (starts_total - s0 !== 7) begin errors++; $display("FAIL init_starts got %0d exp 7", starts_total - s0); end
      checks++; if (acc_x !== 16'h1234) begin errors++; $display("FAIL init_acc_x got %h exp 1234", acc_x); end
      repeat (5) tick();
   endtask
`endif

   task automatic test_burst;
      int k; bit ok; int s0; int v0; logic [6:0] ea;
      s0 = starts_total;
      v0 = sv_total;
      pulse_trig();
      checks++; if (state_ind !== 4'd1) begin errors++; $display("FAIL burst_req_state got %0d exp 1", state_ind); end
      checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL burst_busy got %b exp 1", seq_busy); end
      wait_valid(400, k, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL burst_valid got none exp pulse"); end
      checks++; if (k !== 6 * (D + 2) + 1) begin errors++; $display("FAIL burst_latency got %0d exp %0d", k, 6 * (D + 2) + 1); end
      checks++; if (acc_x !== 16'h1234) begin errors++; $display("FAIL burst_acc_x got %h exp 1234", acc_x); end
      checks++; if (acc_y !== 16'h5678) begin errors++; $display("FAIL burst_acc_y got %h exp 5678", acc_y); end
      checks++; if (acc_z !== 16'h9ABC) begin errors++; $display("FAIL burst_acc_z got %h exp 9abc", acc_z); end
      tick();
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL burst_valid_width got %b exp 0", sample_valid); end
      checks++; if (state_ind !== 4'd0) begin errors++; $display("FAIL burst_idle got %0d exp 0", state_ind); end
      checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL burst_busy_end got %b exp 0", seq_busy); end
      repeat (3) tick();
      checks++; if (starts_total - s0 !== 6) begin errors++; $display("FAIL burst_starts got %0d exp 6", starts_total - s0); end
      checks++; if (sv_total - v0 !== 1) begin errors++; $display("FAIL burst_valid_count got %0d exp 1", sv_total - v0); end
      for (int i = 0; i < 6; i++) begin
         ea = 7'(18 + i);
         checks++; if (log_addr[s0+i] !== ea) begin errors++; $display("FAIL burst_addr%0d got %h exp %h", i, log_addr[s0+i], ea); end
      end
      checks++; if (log_rw[s0+2] !== 1'b1) begin errors++; $display("FAIL burst_rw got %b exp 1", log_rw[s0+2]); end
      checks++; if (log_data[s0+2] !== 8'h00) begin errors++; $display("FAIL burst_data_in got %h exp 00", log_data[s0+2]); end
   endtask

   task automatic test_busy_hold;
      int k; bit ok; int s0;
      s0 = starts_total;
      @(negedge clk);
      busy_force = 1'b1;
      pulse_trig();
      repeat (50) tick();
      checks++; if (starts_total - s0 !== 0) begin errors++; $display("FAIL busy_no_start got %0d exp 0", starts_total - s0); end
      checks++; if (bus.i2c_start !== 1'b0) begin errors++; $display("FAIL busy_start_low got %b exp 0", bus.i2c_start); end
      checks++; if (state_ind !== 4'd1) begin errors++; $display("FAIL busy_state got %0d exp 1", state_ind); end
      @(negedge clk);
      busy_force = 1'b0;
      tick();
      checks++; if (bus.i2c_start !== 1'b1) begin errors++; $display("FAIL busy_release_start got %b exp 1", bus.i2c_start); end
      wait_valid(400, k, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL busy_valid got none exp pulse"); end
      checks++; if (acc_y !== 16'h5678) begin errors++; $display("FAIL busy_acc_y got %h exp 5678", acc_y); end
      checks++; if (acc_z !== 16'h9ABC) begin errors++; $display("FAIL busy_acc_z got %h exp 9abc", acc_z); end
      repeat (3) tick();
   endtask

   task automatic test_timeout;
      int k; bit ok; int s0; int v0;
      s0 = starts_total;
      v0 = sv_total;
      drop_reg = 7'h14;
      drop_en  = 1'b1;
      pulse_trig();
      wait_err(600, k, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_flag got 0 exp 1"); end
      checks++; if (k !== 2 * (D + 2) + 1 + TMO) begin errors++; $display("FAIL tmo_cycles got %0d exp %0d", k, 2 * (D + 2) + 1 + TMO); end
      repeat (5) tick();
      checks++; if (sv_total - v0 !== 0) begin errors++; $display("FAIL tmo_no_valid got %0d exp 0", sv_total - v0); end
      checks++; if (starts_total - s0 !== 3) begin errors++; $display("FAIL tmo_starts got %0d exp 3", starts_total - s0); end
      checks++; if (state_ind !== 4'd0) begin errors++; $display("FAIL tmo_state got %0d exp 0", state_ind); end
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b exp 1", err_timeout); end
      checks++; if (acc_x !== 16'h1234) begin errors++; $display("FAIL tmo_acc_x got %h exp 1234", acc_x); end
      checks++; if (acc_y !== 16'h5678) begin errors++; $display("FAIL tmo_acc_y got %h exp 5678", acc_y); end
      checks++; if (acc_z !== 16'h9ABC) begin errors++; $display("FAIL tmo_acc_z got %h exp 9abc", acc_z); end
      drop_en = 1'b0;
      load_table(48'h0000_7FFF_8001);
      pulse_trig();
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b exp 0", err_timeout); end
      wait_valid(400, k, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_recover got none exp pulse"); end
      checks++; if (acc_x !== 16'h8001) begin errors++; $display("FAIL tmo_rec_acc_x got %h exp 8001", acc_x); end
      checks++; if (acc_y !== 16'h7FFF) begin errors++; $display("FAIL tmo_rec_acc_y got %h exp 7fff", acc_y); end
      checks++; if (acc_z !== 16'h0000) begin errors++; $display("FAIL tmo_rec_acc_z got %h exp 0000", acc_z); end
      repeat (3) tick();
   endtask

   task automatic test_back_to_back;
      int s0; int seen;
      s0   = starts_total;
      seen = 0;
      pulse_trig();
      repeat (10) tick();
      pulse_trig();
      repeat (40) tick();
      pulse_trig();
      for (int c = 0; c < 1000; c++) begin
         tick();
         if (sample_valid) seen++;
      end
      checks++; if (seen !== 2) begin errors++; $display("FAIL b2b_valids got %0d exp 2", seen); end
      checks++; if (starts_total - s0 !== 12) begin errors++; $display("FAIL b2b_starts got %0d exp 12", starts_total - s0); end
      checks++; if (state_ind !== 4'd0) begin errors++; $display("FAIL b2b_idle got %0d exp 0", state_ind); end
   endtask

   task automatic test_reset_mid;
      int k; bit ok; int s0; int s1; int v0; int c;
      s0 = starts_total;
      v0 = sv_total;
      pulse_trig();
      c = 0;
      while (c < 300 && (starts_total - s0) < 4) begin
         tick();
         c++;
      end
      checks++; if (starts_total - s0 !== 4) begin errors++; $display("FAIL rmid_reach got %0d exp 4", starts_total - s0); end
      repeat (5) tick();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (acc_x !== 16'h0) begin errors++; $display("FAIL rmid_acc_x got %h exp 0000", acc_x); end
      checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", seq_busy); end
      checks++; if (state_ind !== 4'd0) begin errors++; $display("FAIL rmid_state got %0d exp 0", state_ind); end
      checks++; if (bus.i2c_reg_addr !== 7'h12) begin errors++; $display("FAIL rmid_reg got %h exp 12", bus.i2c_reg_addr); end
      @(negedge clk);
      rst = 1'b0;
      repeat (80) tick();
      checks++; if (sv_total - v0 !== 0) begin errors++; $display("FAIL rmid_no_valid got %0d exp 0", sv_total - v0); end
      s1 = starts_total;
      pulse_trig();
      wait_valid(400, k, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_valid got none exp pulse"); end
      checks++; if (log_addr[s1] !== 7'h12) begin errors++; $display("FAIL rmid_first_addr got %h exp 12", log_addr[s1]); end
      checks++; if (acc_x !== 16'h8001) begin errors++; $display("FAIL rmid_acc_x_new got %h exp 8001", acc_x); end
      checks++; if (acc_z !== 16'h0000) begin errors++; $display("FAIL rmid_acc_z_new got %h exp 0000", acc_z); end
      repeat (3) tick();
      checks++; if (starts_total - s1 !== 6) begin errors++; $display("FAIL rmid_starts got %0d exp 6", starts_total - s1); end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      load_table(48'h9ABC_5678_1234);
      test_reset();
`ifdef IMU_SEQ_INIT_WRITE_EN
      test_init();
`else
      repeat (3) tick();
`endif
      test_burst();
      test_busy_hold();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
